// File: rtl/count_monitor.sv
// Checks that an upstream T-driven counter steps correctly, locks after LOCK_N good steps and latches faults.
// Optional build macro COUNT_MONITOR_WRAP_CNT_EN adds a 16-bit wrap counter output.
`timescale 1ns/1ps

module count_monitor #(
    parameter int WIDTH  = 3,
    parameter int LOCK_N = 4,
    parameter int ERRW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_cnt,
    output logic             wrap_pulse,
    output logic [1:0]       state
`ifdef COUNT_MONITOR_WRAP_CNT_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;
    localparam logic [3:0] LOCK_C = 4'(LOCK_N);

    logic [WIDTH-1:0] q_prev;
    logic             t_prev;
    logic [3:0]       good_cnt;
    logic [3:0]       good_next;
    logic [WIDTH-1:0] q_exp;
    logic             mismatch;
    logic             wrap_ok;
    logic             wrap_set;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        q_exp     = t_prev ? q_prev + 1'b1 : q_prev;
        mismatch  = (q_in != q_exp);
        // A wrap is by construction a correct step, so no separate mismatch gating is needed.
        wrap_ok   = t_prev && (&q_prev) && (q_in == '0);
        wrap_set  = wrap_ok && ((state == SYNC) || (state == LOCKED));
        good_next = good_cnt + 4'd1;
    end

    assign locked = (state == LOCKED);
    assign err    = (state == FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            q_prev     <= '0;
            t_prev     <= 1'b0;
            good_cnt   <= '0;
            err_cnt    <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            q_prev     <= q_in;
            t_prev     <= t_in;
            wrap_pulse <= wrap_set;
            case (state)
                IDLE: begin
                    state <= SYNC;
                    if (clr) err_cnt <= '0;
                end
                SYNC: begin
                    if (clr) err_cnt <= '0;
                    if (mismatch) begin
                        good_cnt <= '0;
                    end else begin
                        good_cnt <= good_next;
                        if (good_next == LOCK_C) state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (clr) begin
                        state    <= SYNC;
                        err_cnt  <= '0;
                        good_cnt <= '0;
                    end else if (mismatch) begin
                        state   <= FAULT;
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                default: begin
                    // FAULT is sticky: only clr or reset leaves it.
                    if (clr) begin
                        state    <= SYNC;
                        err_cnt  <= '0;
                        good_cnt <= '0;
                    end else if (mismatch) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
            endcase
        end
    end

`ifdef COUNT_MONITOR_WRAP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt <= '0;
        end else if (clr) begin
            wrap_cnt <= '0;
        end else if (wrap_set) begin
            wrap_cnt <= wrap_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock, wrap, fault, saturation/clear, stall and async reset.
`timescale 1ns/1ps

module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in;
    logic [2:0] q_in;
    logic       clr;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       wrap_pulse;
    logic [1:0] state;
`ifdef COUNT_MONITOR_WRAP_CNT_EN
    logic [15:0] wrap_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    count_monitor #(.WIDTH(3), .LOCK_N(4), .ERRW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .t_in       (t_in),
        .q_in       (q_in),
        .clr        (clr),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .wrap_pulse (wrap_pulse),
        .state      (state)
`ifdef COUNT_MONITOR_WRAP_CNT_EN
        ,
        .wrap_cnt   (wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge, one rising edge is applied, outputs are sampled at the next falling edge.
    task automatic cyc(input logic t, input logic [2:0] q, input logic c);
        t_in = t;
        q_in = q;
        clr  = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},  32'(state), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err"},    32'(err), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_wrap"},   32'(wrap_pulse), 32'd0);
`ifdef COUNT_MONITOR_WRAP_CNT_EN
        chk({tag, "_wrapcnt"}, 32'(wrap_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst  = 1'b0;
        t_in = 1'b0;
        q_in = 3'd0;
        clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Lock on an ideal counter counting from 0.
        rst = 1'b1;
        cyc(1'b1, 3'd0, 1'b0);
        chk("idle_to_sync", 32'(state), 32'd1);
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        chk("not_yet_locked", 32'(locked), 32'd0);
        cyc(1'b1, 3'd4, 1'b0);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_state", 32'(state), 32'd2);
        chk("lock_err", 32'(err), 32'd0);
        chk("lock_errcnt", 32'(err_cnt), 32'd0);

        // Wrap 6,7,0.
        cyc(1'b1, 3'd5, 1'b0);
        cyc(1'b1, 3'd6, 1'b0);
        cyc(1'b1, 3'd7, 1'b0);
        chk("prewrap_pulse", 32'(wrap_pulse), 32'd0);
        cyc(1'b1, 3'd0, 1'b0);
        chk("wrap_pulse", 32'(wrap_pulse), 32'd1);
`ifdef COUNT_MONITOR_WRAP_CNT_EN
        chk("wrap_cnt_1", 32'(wrap_cnt), 32'd1);
`endif
        cyc(1'b1, 3'd1, 1'b0);
        chk("wrap_pulse_drop", 32'(wrap_pulse), 32'd0);
        chk("wrap_still_locked", 32'(state), 32'd2);

        // Fault: 3 -> 5 with t_prev=1.
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd5, 1'b0);
        chk("fault_state", 32'(state), 32'd3);
        chk("fault_err", 32'(err), 32'd1);
        chk("fault_locked", 32'(locked), 32'd0);
        chk("fault_errcnt1", 32'(err_cnt), 32'd1);
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd7, 1'b0);
        chk("fault_errcnt3", 32'(err_cnt), 32'd3);
        cyc(1'b1, 3'd0, 1'b0);
        chk("fault_good_step", 32'(err_cnt), 32'd3);
        chk("fault_sticky", 32'(state), 32'd3);

        // Saturation: a constant q with t=1 mismatches every edge.
        for (int i = 0; i < 300; i++) cyc(1'b1, 3'd0, 1'b0);
        chk("sat_errcnt", 32'(err_cnt), 32'd255);
        chk("sat_state", 32'(state), 32'd3);
        cyc(1'b1, 3'd0, 1'b1);
        chk("clr_errcnt", 32'(err_cnt), 32'd0);
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_err", 32'(err), 32'd0);
`ifdef COUNT_MONITOR_WRAP_CNT_EN
        chk("clr_wrapcnt", 32'(wrap_cnt), 32'd0);
`endif

        // Stall: first step mismatches (t_prev was 1), then four correct holds lock.
        cyc(1'b0, 3'd2, 1'b0);
        chk("stall_sync_errcnt", 32'(err_cnt), 32'd0);
        cyc(1'b0, 3'd2, 1'b0);
        cyc(1'b0, 3'd2, 1'b0);
        cyc(1'b0, 3'd2, 1'b0);
        chk("stall_not_locked", 32'(locked), 32'd0);
        cyc(1'b0, 3'd2, 1'b0);
        chk("stall_locked", 32'(locked), 32'd1);
        chk("stall_errcnt", 32'(err_cnt), 32'd0);
        cyc(1'b0, 3'd3, 1'b0);
        chk("stall_fault", 32'(state), 32'd3);
        chk("stall_fault_errcnt", 32'(err_cnt), 32'd1);

        // Asynchronous reset in FAULT, then a fresh lock is required.
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_fault");
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 3'd3, 1'b0);
        cyc(1'b0, 3'd3, 1'b0);
        cyc(1'b0, 3'd3, 1'b0);
        cyc(1'b0, 3'd3, 1'b0);
        chk("relock_not_yet", 32'(locked), 32'd0);
        cyc(1'b0, 3'd3, 1'b0);
        chk("relock_locked", 32'(locked), 32'd1);

        // Wrap again, then reset in LOCKED while wrap_pulse is high.
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd4, 1'b0);
        cyc(1'b1, 3'd5, 1'b0);
        cyc(1'b1, 3'd6, 1'b0);
        cyc(1'b1, 3'd7, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        chk("wrap2_pulse", 32'(wrap_pulse), 32'd1);
        chk("wrap2_locked", 32'(locked), 32'd1);
        #2 rst = 1'b0;
        #1 chk_all_zero("rst_locked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 3: width of the monitored count.
REQ-002 Parameter LOCK_N, default 4, legal range 1..15: consecutive correct steps required to lock.
REQ-003 Parameter ERRW, default 8: width of the error counter.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 t_in  input  1: toggle-enable applied to the upstream counter on the same edge.
REQ-007 q_in  input  WIDTH: count output of the upstream counter.
REQ-008 clr  input  1: synchronous clear of the error status; restarts locking.
REQ-009 locked  output  1: high while in LOCKED.
REQ-010 err  output  1: sticky; high while in FAULT.
REQ-011 err_cnt  output  ERRW: saturating count of mismatches.
REQ-012 wrap_pulse  output  1: one-cycle pulse on a correct wrap from all-ones to zero.
REQ-013 state  output  2: encoding IDLE=0, SYNC=1, LOCKED=2, FAULT=3.

Function
REQ-014 The block shall register q_prev<=q_in and t_prev<=t_in on every clock edge while rst is high.
REQ-015 The expected value shall be (q_prev+1) mod 2^WIDTH when t_prev=1, else q_prev; a step is a mismatch when q_in differs from it.
REQ-016 Checks shall run only when the state is not IDLE; the first edge after reset only captures q_prev and t_prev.
REQ-017 IDLE shall move to SYNC unconditionally on the first edge after reset release.
REQ-018 In SYNC, a 4-bit good-step counter shall increment per correct step and clear on a mismatch; mismatches in SYNC shall not touch err_cnt.
REQ-019 SYNC shall move to LOCKED on the edge where the good-step counter reaches LOCK_N.
REQ-020 LOCKED shall move to FAULT on the first mismatch; that mismatch shall increment err_cnt.
REQ-021 FAULT shall keep checking and increment err_cnt on each further mismatch; FAULT shall be left only by clr or reset.
REQ-022 err_cnt shall saturate at 2^ERRW-1 and shall not wrap.
REQ-023 clr=1 in LOCKED or FAULT shall, on the next edge, set state to SYNC, zero err_cnt and the good-step counter, and drop err; clr in IDLE or SYNC shall only zero err_cnt.
REQ-024 When clr and a mismatch coincide, clr shall win: err_cnt=0 and state=SYNC.
REQ-025 wrap_pulse shall be registered and assert for exactly one cycle, one edge after a correct step with q_prev all-ones, t_prev=1 and q_in=0, in SYNC or LOCKED only.
REQ-026 locked and err shall be decoded from registered state with no combinational path from inputs.
REQ-027 With t_in held 0, a constant q_in shall be a correct step, so the block shall lock on a stalled counter.

Reset
REQ-028 When rst=0, the block shall asynchronously set state=IDLE and clear q_prev, t_prev, the good-step counter, err_cnt, wrap_pulse, locked and err to 0.
REQ-029 Reset asserted mid-operation in any state shall return the block to IDLE immediately; the block shall relock only after a fresh LOCK_N correct steps.

Configuration
REQ-030 The macro COUNT_MONITOR_WRAP_CNT_EN shall control the wrap counter.
REQ-031 With COUNT_MONITOR_WRAP_CNT_EN defined, the block shall add output wrap_cnt (16 bits, reset 0).
REQ-032 wrap_cnt shall increment on every wrap_pulse, wrap at 65535->0, and clear on clr.
REQ-033 Without COUNT_MONITOR_WRAP_CNT_EN, the wrap_cnt port and its logic shall be absent; all other behaviour shall be unchanged.

Verification
REQ-034 Locking: t_in=1, q_in follows an ideal 3-bit counter from 0 after reset release -> locked=1 exactly 1+LOCK_N edges after release, err=0, err_cnt=0.
REQ-035 Wrap: locked, q_in steps 6,7,0 -> wrap_pulse high for one cycle after the 7->0 step; wrap_cnt=1 when the macro is defined.
REQ-036 Fault: locked, q_in jumps 3->5 with t_prev=1 -> state=FAULT, err=1, err_cnt=1; two further bad steps -> err_cnt=3.
REQ-037 Saturation and clear: force 300 mismatches in FAULT with ERRW=8 -> err_cnt=255; then pulse clr on a mismatch cycle -> err_cnt=0, state=SYNC, err=0.
REQ-038 Stall: t_in=0, q_in held at 2 -> locked after LOCK_N steps, no errors; then q_in changes to 3 -> FAULT.
REQ-039 Reset mid-run: assert rst low in LOCKED between clock edges -> all outputs 0 and state=IDLE immediately, with no clock edge required.
